// File: rtl/ex_mem_stage_reg.sv
// ex_mem_stage_reg
// ----------------
// EX/MEM pipeline register of the 64-bit pipelined ARM CPU. Captures the
// selected ALU result, store data, destination register and MEM/WB control
// bits on every rising clock edge. Also owns the architectural NZCV flag
// register, including set-flags gating and a same-cycle forwarding path so
// that a B.cond in EX sees the flags of an ADDS/SUBS issued alongside it.
//
// Ports
//   clk             pipeline clock, rising-edge state updates
//   reset           asynchronous, active-low; clears all state immediately
//   ex_valid        EX stage holds a real instruction
//   ex_result       ALU result-mux output (DATA_W)
//   ex_store_data   forwarded Rt value for STUR (DATA_W)
//   ex_rd           destination register (REG_W)
//   ex_reg_write, ex_mem_write, ex_mem_read, ex_mem_to_reg   control bits
//   ex_xfer_size    memory transfer-size code (4)
//   ex_set_flags    instruction is ADDS/SUBS
//   ex_n/z/c/v      ALU flags for this instruction
//   stall           hold every register, flags included
//   flush           squash the EX instruction, load a bubble
//   mem_*           registered MEM-stage copies of the EX fields
//   flags_q         architectural {N,Z,C,V}
//   flags_fwd       combinational flags seen by B.cond in EX
//
// Pipeline advance semantics (the single place this is documented):
//   An edge with flush=1 loads a bubble (all mem_* zero, flags_q kept).
//   An edge with stall=1 and flush=0 holds everything.
//   Any other edge is a load: mem_* take the EX fields, with control bits
//   qualified by ex_valid so an empty EX slot never writes regs or memory.
//   flush outranks stall when both are asserted.

module ex_mem_stage_reg #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_to_reg,
  input  logic [3:0]        ex_xfer_size,
  input  logic              ex_set_flags,
  input  logic              ex_n,
  input  logic              ex_z,
  input  logic              ex_c,
  input  logic              ex_v,
  input  logic              stall,
  input  logic              flush,
  output logic              mem_valid,
  output logic              mem_reg_write,
  output logic              mem_mem_write,
  output logic              mem_mem_read,
  output logic              mem_mem_to_reg,
  output logic [DATA_W-1:0] mem_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_W-1:0]  mem_rd,
  output logic [3:0]        mem_xfer_size,
  output logic [3:0]        flags_q,
  output logic [3:0]        flags_fwd
);

  logic [3:0] ex_flags;
  logic       flag_update;

  assign ex_flags = {ex_n, ex_z, ex_c, ex_v};

  // A real ADDS/SUBS that is not being squashed produces new flags.
  // Stall does not gate this: a stalled B.cond must still see the flags of
  // the instruction currently sitting in EX.
  assign flag_update = ex_valid & ex_set_flags & ~flush;

  assign flags_fwd = flag_update ? ex_flags : flags_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_valid      <= 1'b0;
      mem_reg_write  <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_to_reg <= 1'b0;
      mem_result     <= '0;
      mem_store_data <= '0;
      mem_rd         <= '0;
      mem_xfer_size  <= '0;
      flags_q        <= '0;
    end else if (flush) begin
      // Bubble: data fields are zeroed too so MEM sees a clean NOP.
      mem_valid      <= 1'b0;
      mem_reg_write  <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_to_reg <= 1'b0;
      mem_result     <= '0;
      mem_store_data <= '0;
      mem_rd         <= '0;
      mem_xfer_size  <= '0;
    end else if (!stall) begin
      mem_valid      <= ex_valid;
      mem_reg_write  <= ex_reg_write  & ex_valid;
      mem_mem_write  <= ex_mem_write  & ex_valid;
      mem_mem_read   <= ex_mem_read   & ex_valid;
      mem_mem_to_reg <= ex_mem_to_reg & ex_valid;
      mem_result     <= ex_result;
      mem_store_data <= ex_store_data;
      // XZR (31) passes through; the register file drops that write.
      mem_rd         <= ex_rd;
      mem_xfer_size  <= ex_xfer_size;
      if (ex_valid && ex_set_flags) begin
        flags_q <= ex_flags;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Bench for ex_mem_stage_reg: directed vectors with literal expectations plus
// a MEM-slot model compared against the DUT on every falling clock edge.

module tb_ex_mem_stage_reg;

  localparam int DATA_W = 64;
  localparam int REG_W  = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic              ex_valid;
  logic [DATA_W-1:0] ex_result;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_W-1:0]  ex_rd;
  logic              ex_reg_write, ex_mem_write, ex_mem_read, ex_mem_to_reg;
  logic [3:0]        ex_xfer_size;
  logic              ex_set_flags;
  logic [3:0]        ex_nzcv;
  logic              stall, flush;

  logic              mem_valid, mem_reg_write, mem_mem_write, mem_mem_read, mem_mem_to_reg;
  logic [DATA_W-1:0] mem_result, mem_store_data;
  logic [REG_W-1:0]  mem_rd;
  logic [3:0]        mem_xfer_size, flags_q, flags_fwd;

  ex_mem_stage_reg #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_result(ex_result), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write),
    .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_xfer_size(ex_xfer_size), .ex_set_flags(ex_set_flags),
    .ex_n(ex_nzcv[3]), .ex_z(ex_nzcv[2]), .ex_c(ex_nzcv[1]), .ex_v(ex_nzcv[0]),
    .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
    .mem_mem_write(mem_mem_write), .mem_mem_read(mem_mem_read),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_result(mem_result),
    .mem_store_data(mem_store_data), .mem_rd(mem_rd),
    .mem_xfer_size(mem_xfer_size), .flags_q(flags_q), .flags_fwd(flags_fwd)
  );

  // ---------------- model: contents of the MEM slot ----------------
  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_write;
    logic              mem_read;
    logic              mem_to_reg;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store_data;
    logic [REG_W-1:0]  rd;
    logic [3:0]        xfer_size;
  } slot_t;

  slot_t      exp_slot;
  logic [3:0] exp_flags;
  bit         chk_en = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_slot  = '0;
    exp_flags = 4'h0;
  endtask

  // What the MEM slot holds after one edge, from the stage's rules.
  task automatic model_edge();
    slot_t nxt;
    if (reset !== 1'b1) return;
    if (flush) begin
      exp_slot = '0;                       // bubble, flags kept
    end else if (!stall) begin
      nxt.valid      = ex_valid;
      nxt.reg_write  = ex_valid && ex_reg_write;
      nxt.mem_write  = ex_valid && ex_mem_write;
      nxt.mem_read   = ex_valid && ex_mem_read;
      nxt.mem_to_reg = ex_valid && ex_mem_to_reg;
      nxt.result     = ex_result;
      nxt.store_data = ex_store_data;
      nxt.rd         = ex_rd;
      nxt.xfer_size  = ex_xfer_size;
      exp_slot       = nxt;
      if (ex_valid && ex_set_flags) exp_flags = ex_nzcv;
    end
  endtask

  // ---------------- scoreboard compare, every falling edge ----------------
  always @(negedge clk) begin
    if (chk_en && reset === 1'b1) begin
      check("valid",      {63'b0, mem_valid},      {63'b0, exp_slot.valid});
      check("reg_write",  {63'b0, mem_reg_write},  {63'b0, exp_slot.reg_write});
      check("mem_write",  {63'b0, mem_mem_write},  {63'b0, exp_slot.mem_write});
      check("mem_read",   {63'b0, mem_mem_read},   {63'b0, exp_slot.mem_read});
      check("mem_to_reg", {63'b0, mem_mem_to_reg}, {63'b0, exp_slot.mem_to_reg});
      check("result",     mem_result,              exp_slot.result);
      check("store_data", mem_store_data,          exp_slot.store_data);
      check("rd",         {59'b0, mem_rd},         {59'b0, exp_slot.rd});
      check("xfer_size",  {60'b0, mem_xfer_size},  {60'b0, exp_slot.xfer_size});
      check("flags_q",    {60'b0, flags_q},        {60'b0, exp_flags});
      check("flags_fwd",  {60'b0, flags_fwd},
            {60'b0, (ex_valid && ex_set_flags && !flush) ? ex_nzcv : exp_flags});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [63:0] res, input logic [63:0] sd,
                       input logic [4:0] rd, input logic [3:0] ctl, input logic [3:0] xs,
                       input logic sf, input logic [3:0] nzcv,
                       input logic st, input logic fl);
    ex_valid      = v;
    ex_result     = res;
    ex_store_data = sd;
    ex_rd         = rd;
    {ex_reg_write, ex_mem_write, ex_mem_read, ex_mem_to_reg} = ctl;
    ex_xfer_size  = xs;
    ex_set_flags  = sf;
    ex_nzcv       = nzcv;
    stall         = st;
    flush         = fl;
  endtask

  // One clock: model advances on the rising edge, next drive happens just
  // after the falling edge (after the scoreboard has compared).
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 64'h0, 64'h0, 5'd0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    idle();
    model_reset();
    #2;
    check("por_valid",  {63'b0, mem_valid}, 64'd0);
    check("por_flags",  {60'b0, flags_q},   64'd0);
    @(negedge clk);
    #1;
    reset  = 1'b1;
    chk_en = 1'b1;

    // Non-zero everything, flags 1010, then async reset between edges.
    drive(1'b1, 64'hFFFF_0000_1234_5678, 64'hAAAA_5555_AAAA_5555, 5'd17, 4'hF, 4'h8,
          1'b1, 4'b1010, 1'b0, 1'b0);
    step();
    check("pre_rst_flags",  {60'b0, flags_q},       64'hA);
    check("pre_rst_result", mem_result,             64'hFFFF_0000_1234_5678);
    reset = 1'b0;
    #1;
    model_reset();
    check("rst_valid",   {63'b0, mem_valid},      64'd0);
    check("rst_mw",      {63'b0, mem_mem_write},  64'd0);
    check("rst_result",  mem_result,              64'd0);
    check("rst_sd",      mem_store_data,          64'd0);
    check("rst_rd",      {59'b0, mem_rd},         64'd0);
    check("rst_flags",   {60'b0, flags_q},        64'd0);
    #1;
    reset = 1'b1;
    step();

    // Plain load.
    drive(1'b1, 64'hDEAD_BEEF_0000_0001, 64'h0, 5'd5, 4'b1000, 4'h3, 1'b0, 4'h0, 1'b0, 1'b0);
    step();
    check("load_result", mem_result,              64'hDEAD_BEEF_0000_0001);
    check("load_rd",     {59'b0, mem_rd},         64'd5);
    check("load_rw",     {63'b0, mem_reg_write},  64'd1);
    check("load_valid",  {63'b0, mem_valid},      64'd1);

    // Stall: A loaded, B presented under stall for 3 edges.
    drive(1'b1, 64'hAAAA, 64'h1, 5'd1, 4'b1000, 4'h1, 1'b0, 4'h0, 1'b0, 1'b0);
    step();
    drive(1'b1, 64'hBBBB, 64'h2, 5'd2, 4'b0100, 4'h2, 1'b0, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold", mem_result, 64'hAAAA);
    end
    stall = 1'b0;
    step();
    check("stall_release", mem_result, 64'hBBBB);
    check("stall_rel_mw",  {63'b0, mem_mem_write}, 64'd1);

    // Flags: SUBS with Z,C.
    drive(1'b1, 64'h0, 64'h0, 5'd31, 4'b1000, 4'h0, 1'b1, 4'b0110, 1'b0, 1'b0);
    #1;
    check("subs_fwd_same", {60'b0, flags_fwd}, 64'h6);
    step();
    check("subs_flags_q",  {60'b0, flags_q},   64'h6);
    check("xzr_rd",        {59'b0, mem_rd},    64'd31);
    drive(1'b1, 64'h7, 64'h0, 5'd3, 4'b1000, 4'h0, 1'b0, 4'b1000, 1'b0, 1'b0);
    step();
    check("add_keeps_flags", {60'b0, flags_q},   64'h6);
    check("add_fwd",         {60'b0, flags_fwd}, 64'h6);

    // Flush and stall together, with a store and a flag setter.
    drive(1'b1, 64'h1234, 64'h5678, 5'd9, 4'b0100, 4'h8, 1'b1, 4'b1001, 1'b1, 1'b1);
    #1;
    check("flush_fwd", {60'b0, flags_fwd}, 64'h6);
    step();
    check("flush_mw",     {63'b0, mem_mem_write}, 64'd0);
    check("flush_valid",  {63'b0, mem_valid},     64'd0);
    check("flush_result", mem_result,             64'd0);
    check("flush_flags",  {60'b0, flags_q},       64'h6);

    // Invalid EX with write and set-flags requests.
    drive(1'b0, 64'h55, 64'h66, 5'd7, 4'b1111, 4'h4, 1'b1, 4'b1111, 1'b0, 1'b0);
    #1;
    check("inv_fwd", {60'b0, flags_fwd}, 64'h6);
    step();
    check("inv_rw",     {63'b0, mem_reg_write}, 64'd0);
    check("inv_flags",  {60'b0, flags_q},       64'h6);
    check("inv_result", mem_result,             64'h55);

    // Stalled flag setter: forwarded now, not committed while stalled.
    drive(1'b1, 64'h9, 64'h0, 5'd4, 4'b1000, 4'h0, 1'b1, 4'b0001, 1'b1, 1'b0);
    #1;
    check("stall_fwd", {60'b0, flags_fwd}, 64'h1);
    step();
    check("stall_flags_q", {60'b0, flags_q}, 64'h6);
    stall = 1'b0;
    step();
    check("unstall_flags_q", {60'b0, flags_q}, 64'h1);

    // Reset while stalled: clears, nothing restored afterwards.
    stall = 1'b1;
    reset = 1'b0;
    #1;
    model_reset();
    check("rst_stall_flags", {60'b0, flags_q}, 64'd0);
    #1;
    reset = 1'b1;
    step();
    check("post_rst_stall_result", mem_result, 64'd0);

    // Mixed vectors, model-checked.
    for (int i = 0; i < 40; i++) begin
      drive($urandom_range(0, 1), {$urandom(), $urandom()}, {$urandom(), $urandom()},
            5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            $urandom_range(0, 1), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
      step();
    end

    idle();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
